// File: rtl/hash_bucket_lookup_pkg.sv
// Shared constants, bucket entry layout and hash-field helpers for the
// hash bucket lookup stage of the SME datapath.
//   HASH_LAT : cycles from hash stage input to its output p
//   ADDR_W   : bucket address width (table depth 2**ADDR_W)
//   FP_W     : fingerprint width (ADDR_W + FP_W <= 64)
//   RULE_W   : rule ID width
//   POS_W    : byte-position tag width
package sme_hash_pkg;

  localparam int HASH_LAT = 10;
  localparam int ADDR_W   = 12;
  localparam int FP_W     = 16;
  localparam int RULE_W   = 16;
  localparam int POS_W    = 16;

  typedef struct packed {
    logic              vld;
    logic [FP_W-1:0]   fp;
    logic [RULE_W-1:0] rule;
  } bucket_entry_t;

  localparam int ENTRY_W = $bits(bucket_entry_t);

  // Bucket index comes from the most significant hash bits.
  function automatic logic [ADDR_W-1:0] bucket_addr(input logic [63:0] hash);
    return hash[63 -: ADDR_W];
  endfunction

  // Fingerprint is the field directly below the bucket index.
  function automatic logic [FP_W-1:0] bucket_fp(input logic [63:0] hash);
    return hash[63-ADDR_W -: FP_W];
  endfunction

endpackage

// File: rtl/hash_bucket_lookup_if.sv
// Bus bundle for hash_bucket_lookup: lookup request sideband, hash stage
// output, table write port, results and status counters.
//   master : traffic source / table loader (drives requests and writes)
//   slave  : the lookup block (drives results, status and counters)
interface hash_bucket_lookup_if
  import sme_hash_pkg::*;
#(
  parameter int POS_W = sme_hash_pkg::POS_W
) ();

  logic               in_valid;
  logic [POS_W-1:0]   in_pos;
  logic [63:0]        hash_in;
  logic               tbl_wr_en;
  logic [ADDR_W-1:0]  tbl_wr_addr;
  logic [ENTRY_W-1:0] tbl_wr_data;
  logic               init_done;
  logic               out_valid;
  logic               out_hit;
  logic [RULE_W-1:0]  out_rule;
  logic [POS_W-1:0]   out_pos;
  logic [31:0]        hit_count;
  logic [31:0]        drop_count;

  modport master (
    output in_valid, in_pos, hash_in, tbl_wr_en, tbl_wr_addr, tbl_wr_data,
    input  init_done, out_valid, out_hit, out_rule, out_pos, hit_count, drop_count
  );

  modport slave (
    input  in_valid, in_pos, hash_in, tbl_wr_en, tbl_wr_addr, tbl_wr_data,
    output init_done, out_valid, out_hit, out_rule, out_pos, hit_count, drop_count
  );

endinterface

// File: rtl/hash_bucket_lookup_bucket_ram.sv
// Simple dual-port bucket table: one write port, one read port, read-first,
// one-cycle registered read. Written so it maps onto block RAM.
//   clk     : clock
//   wr_en   : write strobe
//   wr_addr : write address
//   wr_data : write data
//   rd_addr : read address (read issued every cycle)
//   rd_data : registered read data, old contents on same-address collision
module bucket_ram #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 33
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Both non-blocking: the read samples the array before this edge's write.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/hash_bucket_lookup.sv
// Bucket lookup stage behind the multiplicative hash. Delays the caller's
// valid/position sideband to line up with the hash output, indexes the bucket
// table with the top hash bits, compares the stored fingerprint and emits one
// result per accepted window. Clears the table after every reset.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of hash_bucket_lookup_if (requests, hash, table
//              write port, results, init_done, hit/drop counters)
// Latency from in_valid to out_valid is HASH_LAT+3 cycles, one per cycle.
module hash_bucket_lookup
  import sme_hash_pkg::*;
#(
  parameter int HASH_LAT = sme_hash_pkg::HASH_LAT,
  parameter int POS_W    = sme_hash_pkg::POS_W
) (
  input logic                 clk,
  input logic                 rst,
  hash_bucket_lookup_if.slave bus
);

  localparam int          DEPTH   = 2**ADDR_W;
  localparam logic [0:0]  ST_CLEAR = 1'b0;
  localparam logic [0:0]  ST_RUN   = 1'b1;
  localparam logic [31:0] CNT_MAX  = 32'hFFFF_FFFF;

  logic [0:0]        state_reg;
  logic [ADDR_W-1:0] clr_addr_reg;
  logic              running;
  logic              in_valid_masked;

  assign running         = (state_reg == ST_RUN);
  assign in_valid_masked = bus.in_valid && running;

  // Clear sweep: one entry per cycle, last entry written on the way to RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_CLEAR;
      clr_addr_reg <= '0;
    end else if (state_reg == ST_CLEAR) begin
      clr_addr_reg <= clr_addr_reg + 1'b1;
      if (clr_addr_reg == ADDR_W'(DEPTH - 1)) begin
        state_reg <= ST_RUN;
      end
    end
  end

  // Sideband delay line; the last stage (s0) lines up with hash_in.
  genvar gi;
  generate
    for (gi = 0; gi < HASH_LAT; gi++) begin : g_dl
      logic             v_in;
      logic [POS_W-1:0] p_in;
      logic             v_reg;
      logic [POS_W-1:0] p_reg;

      if (gi == 0) begin : g_head
        assign v_in = in_valid_masked;
        assign p_in = bus.in_pos;
      end else begin : g_tail
        assign v_in = g_dl[gi-1].v_reg;
        assign p_in = g_dl[gi-1].p_reg;
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          v_reg <= 1'b0;
          p_reg <= '0;
        end else begin
          v_reg <= v_in;
          p_reg <= p_in;
        end
      end
    end
  endgenerate

  logic             s0_valid;
  logic [POS_W-1:0] s0_pos;
  assign s0_valid = g_dl[HASH_LAT-1].v_reg;
  assign s0_pos   = g_dl[HASH_LAT-1].p_reg;

  // Stage 1 drives the RAM read address; stage 2 meets the read data.
  logic              s1_valid_reg, s2_valid_reg;
  logic [ADDR_W-1:0] s1_addr_reg;
  logic [FP_W-1:0]   s1_fp_reg, s2_fp_reg;
  logic [POS_W-1:0]  s1_pos_reg, s2_pos_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s1_addr_reg  <= '0;
      s1_fp_reg    <= '0;
      s1_pos_reg   <= '0;
      s2_valid_reg <= 1'b0;
      s2_fp_reg    <= '0;
      s2_pos_reg   <= '0;
    end else begin
      s1_valid_reg <= s0_valid;
      s1_addr_reg  <= bucket_addr(bus.hash_in);
      s1_fp_reg    <= bucket_fp(bus.hash_in);
      s1_pos_reg   <= s0_pos;
      s2_valid_reg <= s1_valid_reg;
      s2_fp_reg    <= s1_fp_reg;
      s2_pos_reg   <= s1_pos_reg;
    end
  end

  // Write port belongs to the clear sweep until RUN, then to the caller.
  logic               ram_wr_en;
  logic [ADDR_W-1:0]  ram_wr_addr;
  logic [ENTRY_W-1:0] ram_wr_data;
  logic [ENTRY_W-1:0] ram_rd_data;

  assign ram_wr_en   = !rst && (running ? bus.tbl_wr_en : 1'b1);
  assign ram_wr_addr = running ? bus.tbl_wr_addr : clr_addr_reg;
  assign ram_wr_data = running ? bus.tbl_wr_data : '0;

  bucket_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (ENTRY_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (ram_wr_en),
    .wr_addr (ram_wr_addr),
    .wr_data (ram_wr_data),
    .rd_addr (s1_addr_reg),
    .rd_data (ram_rd_data)
  );

  bucket_entry_t rd_entry;
  logic          lookup_hit;
  assign rd_entry   = ram_rd_data;
  assign lookup_hit = rd_entry.vld && (rd_entry.fp == s2_fp_reg);

  logic              out_valid_reg, out_hit_reg;
  logic [RULE_W-1:0] out_rule_reg;
  logic [POS_W-1:0]  out_pos_reg;
  logic [31:0]       hit_count_reg, drop_count_reg;

  // Rule/pos only move on a valid result so they hold across idle cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_hit_reg   <= 1'b0;
      out_rule_reg  <= '0;
      out_pos_reg   <= '0;
    end else begin
      out_valid_reg <= s2_valid_reg;
      out_hit_reg   <= s2_valid_reg && lookup_hit;
      if (s2_valid_reg) begin
        out_rule_reg <= lookup_hit ? rd_entry.rule : '0;
        out_pos_reg  <= s2_pos_reg;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count_reg  <= '0;
      drop_count_reg <= '0;
    end else begin
      if (out_valid_reg && out_hit_reg && hit_count_reg != CNT_MAX) begin
        hit_count_reg <= hit_count_reg + 32'd1;
      end
      if (bus.in_valid && !running && drop_count_reg != CNT_MAX) begin
        drop_count_reg <= drop_count_reg + 32'd1;
      end
    end
  end

  assign bus.init_done  = running;
  assign bus.out_valid  = out_valid_reg;
  assign bus.out_hit    = out_hit_reg;
  assign bus.out_rule   = out_rule_reg;
  assign bus.out_pos    = out_pos_reg;
  assign bus.hit_count  = hit_count_reg;
  assign bus.drop_count = drop_count_reg;

endmodule
